// File: rtl/debug_instr_encoder.sv
// RV32I instruction encoder feeding a small output FIFO (head shown combinationally, zeroed when empty).
// Optional immediate range checking is enabled by defining DEBUG_INSTR_ENC_RANGE_CHECK_EN.
module debug_instr_encoder #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_fmt,
    input  logic [6:0]  in_opcode,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] raw_instr;
    logic        raw_err;
    logic [31:0] enc_instr;
    logic        enc_err;

    always_comb begin
        raw_instr = NOP;
        raw_err   = 1'b1;
        case (in_fmt)
            3'd0: begin
                raw_instr = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                raw_err   = 1'b0;
            end
            3'd1: begin
                raw_instr = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                raw_err   = 1'b0;
            end
            3'd2: begin
                raw_instr = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                raw_err   = 1'b0;
            end
            3'd3: begin
                raw_instr = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                             in_imm[4:1], in_imm[11], in_opcode};
                raw_err   = 1'b0;
            end
            3'd4: begin
                raw_instr = {in_imm[31:12], in_rd, in_opcode};
                raw_err   = 1'b0;
            end
            3'd5: begin
                raw_instr = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
                raw_err   = 1'b0;
            end
            default: begin
                raw_instr = NOP;
                raw_err   = 1'b1;
            end
        endcase
    end

`ifdef DEBUG_INSTR_ENC_RANGE_CHECK_EN
    logic range_bad;

    // An immediate is in range when its upper bits are a sign extension of the top encoded bit.
    always_comb begin
        range_bad = 1'b0;
        case (in_fmt)
            3'd1, 3'd2: range_bad = (in_imm[31:11] != {21{in_imm[11]}});
            3'd3:       range_bad = (in_imm[31:12] != {20{in_imm[12]}}) || in_imm[0];
            3'd4:       range_bad = (in_imm[11:0] != 12'd0);
            3'd5:       range_bad = (in_imm[31:20] != {12{in_imm[20]}}) || in_imm[0];
            default:    range_bad = 1'b0;
        endcase
    end

    assign enc_instr = range_bad ? NOP : raw_instr;
    assign enc_err   = raw_err | range_bad;
`else
    assign enc_instr = raw_instr;
    assign enc_err   = raw_err;
`endif

    logic [31:0]      mem_instr [FIFO_DEPTH];
    logic             mem_err   [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             init_q;
    logic             full;
    logic             push;
    logic             pop;

    assign full      = (count_q == CNT_W'(FIFO_DEPTH));
    assign in_ready  = init_q && !full;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_instr = out_valid ? mem_instr[rd_ptr_q] : 32'd0;
    assign out_err   = out_valid ? mem_err[rd_ptr_q] : 1'b0;

    // Depth is a power of two, so pointer overflow is the modulo wrap.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            init_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            init_q   <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible while counted.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_instr[gi] <= enc_instr;
                    mem_err[gi]   <= enc_err;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_debug_instr_encoder.sv
// Directed self-checking bench for debug_instr_encoder (FIFO_DEPTH=2).
// Expectations for the range-check cases follow DEBUG_INSTR_ENC_RANGE_CHECK_EN.
module tb_debug_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fmt;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_err;

    int checks   = 0;
    int failures = 0;

    debug_instr_encoder #(.FIFO_DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_opcode (in_opcode),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_funct3 (in_funct3),
        .in_funct7 (in_funct7),
        .in_imm    (in_imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    task automatic drive_cmd(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    endtask

    // Pushes the already-driven command into an empty FIFO, samples the head one cycle later, then pops it.
    task automatic encode_one(input string name, output logic ok, output logic vld,
                              output logic [31:0] instr, output logic err);
        int n = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        vld = out_valid; instr = out_instr; err = out_err;
        $display("txn %s: valid=%b instr=%h err=%b", name, vld, instr, err);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive_cmd(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        #12;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++; $display("FAIL reset_handshake got valid=%b ready=%b exp 0/0", out_valid, in_ready);
        end
        checks++;
        if (out_instr !== 32'd0 || out_err !== 1'b0) begin
            failures++; $display("FAIL reset_outputs got instr=%h err=%b exp 0/0", out_instr, out_err);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_release got ready=%b valid=%b exp 1/0", in_ready, out_valid);
        end
        $display("txn reset: released, in_ready=%b", in_ready);
    endtask

    task automatic test_i_type;
        logic ok, vld, err; logic [31:0] instr;
        drive_cmd(3'd1, 7'h13, 5'd1, 5'd0, 5'd9, 3'd0, 7'h55, 32'hFFFF_FFFF);
        encode_one("addi_m1", ok, vld, instr, err);
        checks++;
        if (ok !== 1'b1 || vld !== 1'b1) begin
            failures++; $display("FAIL i_latency got ready=%b valid=%b exp 1/1", ok, vld);
        end
        checks++;
        if (instr !== 32'hFFF0_0093 || err !== 1'b0) begin
            failures++; $display("FAIL i_encode got %h/%b exp fff00093/0", instr, err);
        end
        checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'd0 || out_err !== 1'b0) begin
            failures++; $display("FAIL idle_zero got valid=%b instr=%h err=%b exp 0/0/0", out_valid, out_instr, out_err);
        end
    endtask

    task automatic test_s_j_r_u;
        logic ok, vld, err; logic [31:0] instr;
        drive_cmd(3'd2, 7'h23, 5'd17, 5'd3, 5'd2, 3'd2, 7'h7F, 32'd8);
        encode_one("sw", ok, vld, instr, err);
        checks++;
        if (instr !== 32'h0021_A423 || err !== 1'b0) begin
            failures++; $display("FAIL s_encode got %h/%b exp 0021a423/0", instr, err);
        end
        drive_cmd(3'd5, 7'h6F, 5'd1, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h800);
        encode_one("jal", ok, vld, instr, err);
        checks++;
        if (instr !== 32'h0010_00EF || err !== 1'b0) begin
            failures++; $display("FAIL j_encode got %h/%b exp 001000ef/0", instr, err);
        end
        drive_cmd(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'hDEAD_BEEF);
        encode_one("add", ok, vld, instr, err);
        checks++;
        if (instr !== 32'h0020_81B3 || err !== 1'b0) begin
            failures++; $display("FAIL r_add got %h/%b exp 002081b3/0", instr, err);
        end
        drive_cmd(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0);
        encode_one("sub", ok, vld, instr, err);
        checks++;
        if (instr !== 32'h4020_81B3) begin
            failures++; $display("FAIL r_sub got %h exp 402081b3", instr);
        end
        drive_cmd(3'd4, 7'h37, 5'd5, 5'd31, 5'd31, 3'd7, 7'h7F, 32'h1234_5000);
        encode_one("lui", ok, vld, instr, err);
        checks++;
        if (instr !== 32'h1234_52B7 || err !== 1'b0) begin
            failures++; $display("FAIL u_encode got %h/%b exp 123452b7/0", instr, err);
        end
    endtask

    task automatic test_b_type;
        logic ok, vld, err; logic [31:0] instr;
        drive_cmd(3'd3, 7'h63, 5'd9, 5'd1, 5'd2, 3'd0, 7'h7F, 32'd8);
        encode_one("beq_p8", ok, vld, instr, err);
        checks++;
        if (instr !== 32'h0020_8463 || err !== 1'b0) begin
            failures++; $display("FAIL b_pos got %h/%b exp 00208463/0", instr, err);
        end
        drive_cmd(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 7'h00, 32'hFFFF_FFFC);
        encode_one("bne_m4", ok, vld, instr, err);
        checks++;
        if (instr !== 32'hFE20_9EE3 || err !== 1'b0) begin
            failures++; $display("FAIL b_neg got %h/%b exp fe209ee3/0", instr, err);
        end
        drive_cmd(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
        encode_one("beq_odd", ok, vld, instr, err);
        checks++;
`ifdef DEBUG_INSTR_ENC_RANGE_CHECK_EN
        if (instr !== 32'h0000_0013 || err !== 1'b1) begin
            failures++; $display("FAIL b_odd got %h/%b exp 00000013/1", instr, err);
        end
`else
        if (instr !== 32'h0000_0163 || err !== 1'b0) begin
            failures++; $display("FAIL b_odd got %h/%b exp 00000163/0", instr, err);
        end
`endif
        drive_cmd(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5001);
        encode_one("lui_lowbits", ok, vld, instr, err);
        checks++;
`ifdef DEBUG_INSTR_ENC_RANGE_CHECK_EN
        if (instr !== 32'h0000_0013 || err !== 1'b1) begin
            failures++; $display("FAIL u_lowbits got %h/%b exp 00000013/1", instr, err);
        end
`else
        if (instr !== 32'h1234_52B7 || err !== 1'b0) begin
            failures++; $display("FAIL u_lowbits got %h/%b exp 123452b7/0", instr, err);
        end
`endif
    endtask

    task automatic test_illegal;
        logic ok, vld, err; logic [31:0] instr;
        drive_cmd(3'd6, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0);
        encode_one("fmt6", ok, vld, instr, err);
        checks++;
        if (vld !== 1'b1 || instr !== 32'h0000_0013 || err !== 1'b1) begin
            failures++; $display("FAIL illegal6 got %b/%h/%b exp 1/00000013/1", vld, instr, err);
        end
        drive_cmd(3'd7, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h800);
        encode_one("fmt7", ok, vld, instr, err);
        checks++;
        if (instr !== 32'h0000_0013 || err !== 1'b1) begin
            failures++; $display("FAIL illegal7 got %h/%b exp 00000013/1", instr, err);
        end
    endtask

    task automatic test_fifo_full;
        logic [31:0] exp_w [3];
        int got = 0;
        logic acc;
        exp_w[0] = 32'h0010_0093; exp_w[1] = 32'h0020_0113; exp_w[2] = 32'h0030_0193;
        out_ready = 1'b0;
        drive_cmd(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        drive_cmd(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_instr !== exp_w[0]) begin
            failures++; $display("FAIL fifo_full got ready=%b head=%h exp 0/%h", in_ready, out_instr, exp_w[0]);
        end
        drive_cmd(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
        in_valid = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_instr !== exp_w[0]) begin
            failures++; $display("FAIL fifo_hold got ready=%b valid=%b head=%h exp 0/1/%h", in_ready, out_valid, out_instr, exp_w[0]);
        end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 12 && got < 3; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                $display("txn fifo pop %0d: instr=%h", got, out_instr);
                checks++;
                if (out_instr !== exp_w[got]) begin
                    failures++; $display("FAIL fifo_order%0d got %h exp %h", got, out_instr, exp_w[got]);
                end
                got++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        checks++;
        if (got !== 3 || out_valid !== 1'b0) begin
            failures++; $display("FAIL fifo_drain got words=%0d valid=%b exp 3/0", got, out_valid);
        end
    endtask

    task automatic test_back_to_back;
        int sent = 0, got = 0, stalls = 0;
        logic acc;
        logic [31:0] exp_w;
        out_ready = 1'b1;
        drive_cmd(3'd1, 7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 30 && got < 4; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                exp_w = ((32'd4 + 32'(got)) << 20) | ((32'd4 + 32'(got)) << 7) | 32'h13;
                $display("txn b2b pop %0d: instr=%h", got, out_instr);
                checks++;
                if (out_instr !== exp_w) begin
                    failures++; $display("FAIL b2b_word%0d got %h exp %h", got, out_instr, exp_w);
                end
                got++;
            end
            if (in_valid && !in_ready) stalls++;
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                if (sent < 4)
                    drive_cmd(3'd1, 7'h13, 5'(4 + sent), 5'd0, 5'd0, 3'd0, 7'h00, 32'(4 + sent));
                else
                    in_valid = 1'b0;
            end
        end
        out_ready = 1'b0;
        checks++;
        if (got !== 4 || stalls !== 0) begin
            failures++; $display("FAIL b2b_stream got words=%0d stalls=%0d exp 4/0", got, stalls);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        drive_cmd(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            failures++; $display("FAIL midrst_pre got valid=%b exp 1", out_valid);
        end
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_instr !== 32'd0 || out_err !== 1'b0) begin
            failures++; $display("FAIL midrst_async got valid=%b ready=%b instr=%h err=%b exp 0/0/0/0",
                                 out_valid, in_ready, out_instr, out_err);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++; $display("FAIL midrst_release got ready=%b valid=%b exp 1/0", in_ready, out_valid);
        end
        $display("txn midreset: ready=%b valid=%b", in_ready, out_valid);
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_s_j_r_u();
        test_b_type();
        test_illegal();
        test_fifo_full();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
